// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812 frame controller and RZ encoder.
package ws2812_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PREP  = 2'd1,
        SEND  = 2'd2,
        LATCH = 2'd3
    } state_t;

    localparam int BITS_PER_LED     = 24;
    localparam int BIT_CYCLES_50M   = 60;
    localparam int RESET_CYCLES_50M = 3000;

    // Width for an index 0..n-1 that stays at least one bit wide when n == 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ws2812_phase_cnt.sv
// Free-running symbol phase counter 0..BIT_CYCLES-1; wrap marks the shift edge.
// Shared with the RZ encoder so both blocks agree on symbol boundaries.
module ws2812_phase_cnt #(
    parameter int BIT_CYCLES = 60,
    parameter int PW         = $clog2(BIT_CYCLES)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [PW-1:0] phase,
    output logic          wrap
);

    assign wrap = (phase == PW'(BIT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (wrap) begin
            phase <= '0;
        end else begin
            phase <= phase + PW'(1);
        end
    end

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// WS2812 frame scheduler: fetches pixel words, loads the RZ encoder on symbol
// boundaries and gates its output. WS2812_AUTO_REFRESH_EN repeats frames back-to-back.
module ws2812_frame_ctrl
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS     = 64,
    parameter int BIT_CYCLES   = BIT_CYCLES_50M,
    parameter int RESET_CYCLES = RESET_CYCLES_50M,
    parameter int AW           = cnt_width(NUM_LEDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          frame_done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [23:0]   rd_data,
    output logic [23:0]   rgb,
    output logic          load,
    input  logic          rz_in,
    output logic          led_dout,
    output logic [1:0]    fsm_state
);

    localparam int PW  = $clog2(BIT_CYCLES);
    localparam int LW  = $clog2(RESET_CYCLES + 1);
    localparam int PCW = AW + 1;

    state_t          state, state_nxt;
    logic [PW-1:0]   phase;
    logic            wrap;
    logic [4:0]      bit_cnt;
    logic [PCW-1:0]  slot_cnt;
    logic [LW-1:0]   lat_cnt;
    logic            armed;
    logic            gate;
    logic            rd_pend;
    logic            ph_first, ph_pre;
    logic            start_ok, gate_on, gate_off, lat_end;

    ws2812_phase_cnt #(
        .BIT_CYCLES (BIT_CYCLES),
        .PW         (PW)
    ) u_phase (
        .clk   (clk),
        .rst_n (rst_n),
        .phase (phase),
        .wrap  (wrap)
    );

    assign ph_first = (phase == '0);
    assign ph_pre   = (phase == PW'(BIT_CYCLES - 2));
    assign start_ok = start && (state == IDLE) && !frame_done;

    // bit_cnt/slot_cnt count symbol periods from the first load; the gate opens and
    // closes one symbol after a load slot boundary because the encoder output is registered.
    assign gate_on  = (state == SEND) && !gate && ph_first && (bit_cnt == 5'd1) && (slot_cnt == '0);
    assign gate_off = (state == SEND) && gate && ph_first && (bit_cnt == 5'd1)
                      && (slot_cnt == PCW'(NUM_LEDS));
    assign lat_end  = (state == LATCH) && (lat_cnt == LW'(RESET_CYCLES - 1));

    assign load      = (state == SEND) && ph_first && (bit_cnt == '0) && (slot_cnt < PCW'(NUM_LEDS));
    assign busy      = (state != IDLE);
    assign led_dout  = rz_in & gate;
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pixel read: rd_en is a one-cycle request with no back-pressure; rd_data is valid
    // exactly one cycle later and is captured into rgb at the end of that cycle.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) state_nxt = PREP;
            end
            PREP: begin
                if (ph_pre) begin
                    rd_en     = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (ph_pre && (bit_cnt == 5'(BITS_PER_LED - 1)) && (slot_cnt < PCW'(NUM_LEDS - 1)))
                    rd_en = 1'b1;
                if (gate_off) state_nxt = LATCH;
            end
            LATCH: begin
                if (lat_end) begin
`ifdef WS2812_AUTO_REFRESH_EN
                    state_nxt = PREP;
`else
                    state_nxt = IDLE;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend    <= 1'b0;
            rgb        <= '0;
            rd_addr    <= '0;
            frame_done <= 1'b0;
            bit_cnt    <= '0;
            slot_cnt   <= '0;
            armed      <= 1'b0;
            gate       <= 1'b0;
            lat_cnt    <= '0;
        end else begin
            rd_pend    <= rd_en;
            frame_done <= lat_end;
            if (rd_pend) rgb <= rd_data;

            if (state == IDLE || state == LATCH) begin
                rd_addr <= '0;
            end else if (rd_en) begin
                rd_addr <= rd_addr + AW'(1);
            end

            if (state == PREP) begin
                bit_cnt  <= '0;
                slot_cnt <= '0;
                armed    <= 1'b0;
            end else if (state == SEND) begin
                if (load) armed <= 1'b1;
                if (wrap && armed) begin
                    if (bit_cnt == 5'(BITS_PER_LED - 1)) begin
                        bit_cnt  <= '0;
                        slot_cnt <= slot_cnt + PCW'(1);
                    end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                end
            end

            if (gate_on) begin
                gate <= 1'b1;
            end else if (gate_off) begin
                gate <= 1'b0;
            end

            if (state == LATCH) begin
                lat_cnt <= lat_cnt + LW'(1);
            end else begin
                lat_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/ws2812_frame_ctrl.md
# ws2812_frame_ctrl

Frame scheduler for the WS2812 serial LED chain. On a start pulse it fetches NUM_LEDS 24-bit GRB words from a pixel RAM and hands each one to the RZ encoder at the correct symbol boundary. It gates the encoder's free-running output so the line carries exactly 24×NUM_LEDS symbols, then holds the line low for the latch/reset gap. It sits between the pixel RAM and the RZ encoder, and drives the LED data pin.

## Interface

- NUM_LEDS, 64: LEDs in the chain, ≥1.
- BIT_CYCLES, 60: clocks per symbol; must equal the encoder's symbol period (1.2 µs at 50 MHz).
- RESET_CYCLES, 3000: low-time latch gap (60 µs at 50 MHz); ≥1.
- AW, $clog2(NUM_LEDS): pixel address width.
- clk  in  1  system clock; one clock domain only.
- rst_n  in  1  reset, asynchronous, active-low; also resets the encoder.
- start  in  1  one-cycle request to send one frame; ignored while busy=1.
- busy  out  1  high from the accepted start until frame_done.
- frame_done  out  1  one-cycle pulse at the end of the latch gap.
- rd_en  out  1  pixel RAM read strobe.
- rd_addr  out  AW  pixel index 0..NUM_LEDS-1.
- rd_data  in  24  GRB word; valid the cycle after rd_en.
- rgb  out  24  registered word to the encoder's RGB input.
- load  out  1  one-cycle pulse to the encoder's done_sig.
- rz_in  in  1  encoder's RZ_data.
- led_dout  out  1  rz_in AND gate; drives the LED pin.

## Operation

- **Phase counter.** 0..BIT_CYCLES-1, resets to 0, increments every clock, wraps after BIT_CYCLES-1. It runs in lockstep with the encoder's symbol counter because both leave reset on the same edge.
- **Shift edge.** The clock edge at which the phase wraps from BIT_CYCLES-1 to 0. The encoder captures the next bit on this edge.
- **States:**
  - IDLE: a start is accepted here → PREP, and busy goes high the next cycle.
  - PREP: wait for phase==BIT_CYCLES-2 → SEND.
  - SEND: transmit the pixels.
  - LATCH: count RESET_CYCLES, then → IDLE with a frame_done pulse.
- **Pixel fetch.**
  - rd_en=1 in the cycle where phase==BIT_CYCLES-2 of the symbol period before each load.
  - rgb captures rd_data on the following edge.
  - load=1 during a phase==0 cycle.
- **Load cadence.** Pixel p loads at phase 0 of symbol period 24p, counted from the first load. The 24th shift after a load consumes bit 0 before the next load, and load never coincides with a shift edge.
- **Address sequence.** rd_addr runs 0,1,…,NUM_LEDS-1. No read is issued after the last pixel.
- **Gate.**
  - Registered and reset to 0.
  - Set on the edge ending the phase-0 cycle that follows the first shift edge after the first load.
  - Cleared on the same-phase edge exactly 24×NUM_LEDS symbol periods later. SEND → LATCH on that edge.
- **Idle line.** The encoder emits 0-codes whenever it idles, so led_dout is low whenever gate=0.
- **Counter widths.** Bit counter 5 bits (0..23). Pixel counter AW+1 bits. Latch counter $clog2(RESET_CYCLES+1) bits. No counter may wrap inside a frame.
- **Start handling.** start during busy is dropped, not queued. start in the same cycle as frame_done is dropped.
- **Reset mid-frame.** Every output returns to 0 immediately (asynchronously) and the state returns to IDLE. The line is low.

## Timing

- **Reset values:** busy, frame_done, rd_en, load, gate, led_dout = 0; rd_addr = 0; rgb = 0.
- **Start latency.** From the start cycle to the first rd_en is at most BIT_CYCLES+1 cycles, depending on phase. load follows rd_en by 2 cycles.
- **Frame length.** Gate high for exactly 24×NUM_LEDS×BIT_CYCLES cycles. frame_done occurs RESET_CYCLES cycles after gate falls.
- **Inter-load spacing.** Exactly 24×BIT_CYCLES cycles.

## Configuration

- **WS2812_AUTO_REFRESH_EN defined:** at the end of LATCH the controller re-enters PREP automatically, with busy kept high. frame_done still pulses once per frame. A start while running is ignored. Deasserting is by reset only.
- **Undefined:** one frame per accepted start, as described in Operation.

## Structure

- **Shared package ws2812_pkg:**
  - state enum (IDLE, PREP, SEND, LATCH)
  - BITS_PER_LED = 24
  - default timing constants BIT_CYCLES_50M = 60 and RESET_CYCLES_50M = 3000
- **Sub-module ws2812_phase_cnt:** the phase counter with a wrap output. Reusable by the encoder so both blocks share one phase definition.

## Test plan

Common bench setup: NUM_LEDS=2, BIT_CYCLES=60, RESET_CYCLES=3000, with the real encoder instantiated.

- **Basic frame.** RAM = {0xFF0000, 0x00000F}, pulse start → led_dout shows 48 symbols:
  - 8 one-codes (40 high/20 low) then 16 zero-codes (20/40);
  - then 20 zero-codes then 4 one-codes;
  - then 3000 low cycles and a frame_done pulse; busy drops on the same edge.
- **Start while busy.** start mid-frame → no extra rd_en; exactly 2 reads per frame at addresses 0 and 1.
- **Load alignment.** Issue start at each phase 0..59 → every load occurs at phase 0. Consecutive loads are exactly 1440 cycles apart. No load lands on a shift edge.
- **Reset mid-operation.** Assert rst_n low at symbol 30 → all outputs 0 within the reset cycle. After release, the line stays low and no rd_en occurs until a new start.
- **Idle line.** Hold start low for 10000 cycles → led_dout stays 0 throughout.
- **WS2812_AUTO_REFRESH_EN.** Compile with the macro, single start → frames repeat back-to-back with a 3000-cycle gap. frame_done pulses once per frame and busy stays 1.
